mem_bist: RTL and testbench

Hardware built-in self-test engine that drives the 32x8 memory over the same bus the memory test bench uses: read, write, addr, data_in out; data_out back. It sits directly upstream of the memory. On a start pulse it fills every location with a selected pattern, then reads each location back and checks it against the regenerated expected value. It reports pass/fail, an error count and the first failing address.

---
 rtl/mem_bist_pkg.sv | 43 ++++
 rtl/mem_bist_lfsr.sv | 31 +++
 rtl/mem_bist.sv | 157 +++++++++++++++
 tb/tb_mem_bist.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bist_pkg.sv
// Shared types and pattern helpers for the memory BIST engine.
package mem_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_RD    = 3'd2,
    ST_CHK   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    MODE_ZERO  = 2'b00,
    MODE_ADDR  = 2'b01,
    MODE_RAND  = 2'b10,
    MODE_CHECK = 2'b11
  } mode_e;

  // Feedback taps at bits 7, 5, 4 and 3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] PAT_EVEN  = 8'h55;
  localparam logic [7:0] PAT_ODD   = 8'hAA;

  function automatic logic [7:0] lfsr_step(input logic [7:0] d);
    return {d[6:0], ^(d & LFSR_TAPS)};
  endfunction

  // Pattern value for one location; addr is zero-extended to 8 bits.
  function automatic logic [7:0] expected_data(input mode_e m, input logic [7:0] a,
                                               input logic [7:0] lfsr);
    logic [7:0] r;
    r = 8'h00;
    case (m)
      MODE_ZERO:  r = 8'h00;
      MODE_ADDR:  r = a;
      MODE_RAND:  r = lfsr;
      MODE_CHECK: r = a[0] ? PAT_ODD : PAT_EVEN;
      default:    r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_bist_lfsr.sv
// 8-bit Fibonacci LFSR; load has priority over advance.
module mem_bist_lfsr
  import mem_bist_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       advance,
  output logic [7:0] value,
  output logic [7:0] value_next
);

  // Next value is exposed so the FSM can look one step ahead.
  always_comb begin
    value_next = lfsr_step(value);
  end

  // Shift register with synchronous reload to the seed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= SEED;
    end else if (load) begin
      value <= SEED;
    end else if (advance) begin
      value <= value_next;
    end
  end

endmodule

// File: rtl/mem_bist.sv
// Memory BIST engine: fills every location with a pattern, reads it back and
// reports error count, first failing address and pass/fail.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start; read/write/busy low
// ST_WRITE | one write per cycle, addr 0..DEPTH-1
// ST_RD    | read strobe at current addr
// ST_CHK   | compare data_out with regenerated pattern, then step addr
// ST_DONE  | one-cycle done pulse, latch pass
module mem_bist
  import mem_bist_pkg::*;
#(
  parameter int         ADDR_W    = 5,
  parameter int         DATA_W    = 8,
  parameter int         DEPTH     = 32,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_count,
  output logic              first_err_valid,
  output logic [ADDR_W-1:0] first_err_addr
);

  // An all-zero seed would lock the LFSR, so it is bumped to 1.
  localparam logic [7:0]        SEED_EFF  = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   ERR_MAX   = (ADDR_W + 1)'(DEPTH);

  state_e            state;
  mode_e             mode_q;
  logic [7:0]        lfsr_val;
  logic [7:0]        lfsr_next;
  logic              lfsr_load;
  logic              lfsr_adv;
  logic [ADDR_W-1:0] addr_inc;
  logic              at_last;
  logic [DATA_W-1:0] chk_expected;
  logic              mismatch;

  // LFSR tracks the pattern value of the current addr in both passes.
  always_comb begin
    at_last      = (addr == LAST_ADDR);
    addr_inc     = addr + ADDR_W'(1);
    lfsr_load    = ((state == ST_IDLE) && start) || ((state == ST_WRITE) && at_last);
    lfsr_adv     = (state == ST_WRITE) || (state == ST_CHK);
    chk_expected = DATA_W'(expected_data(mode_q, 8'(addr), lfsr_val));
    mismatch     = (data_out != chk_expected);
  end

  mem_bist_lfsr #(
    .SEED (SEED_EFF)
  ) u_lfsr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (lfsr_load),
    .advance    (lfsr_adv),
    .value      (lfsr_val),
    .value_next (lfsr_next)
  );

  // Sequencer with registered bus strobes and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      mode_q          <= MODE_ZERO;
      read            <= 1'b0;
      write           <= 1'b0;
      addr            <= '0;
      data_in         <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_addr  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state           <= ST_WRITE;
            mode_q          <= mode_e'(mode);
            write           <= 1'b1;
            read            <= 1'b0;
            addr            <= '0;
            data_in         <= DATA_W'(expected_data(mode_e'(mode), 8'h00, SEED_EFF));
            busy            <= 1'b1;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
          end
        end
        ST_WRITE: begin
          if (at_last) begin
            state <= ST_RD;
            write <= 1'b0;
            read  <= 1'b1;
            addr  <= '0;
          end else begin
            addr    <= addr_inc;
            data_in <= DATA_W'(expected_data(mode_q, 8'(addr_inc), lfsr_next));
          end
        end
        ST_RD: begin
          state <= ST_CHK;
          read  <= 1'b0;
        end
        ST_CHK: begin
          if (mismatch) begin
            if (err_count != ERR_MAX) begin
              err_count <= err_count + (ADDR_W + 1)'(1);
            end
            if (!first_err_valid) begin
              first_err_valid <= 1'b1;
              first_err_addr  <= addr;
            end
          end
          if (at_last) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            state <= ST_RD;
            addr  <= addr_inc;
            read  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          pass  <= (err_count == '0);
        end
        default: begin
          state <= ST_IDLE;
          read  <= 1'b0;
          write <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bist.sv
// Self-checking bench for mem_bist with a 32x8 memory model and stuck-at faults.
module tb_mem_bist;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] mode;
  logic       read;
  logic       write;
  logic [4:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [5:0] err_count;
  logic       first_err_valid;
  logic [4:0] first_err_addr;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0] a;
    logic [7:0] d;
  } wr_t;
  wr_t exp_q[$];

  logic [7:0] mem   [32];
  logic [7:0] stuck [32];
  logic [7:0] obs_wdata [32];

  // expected results of the current run
  int         exp_errs;
  logic       exp_fv;
  logic [4:0] exp_faddr;

  mem_bist dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .mode            (mode),
    .read            (read),
    .write           (write),
    .addr            (addr),
    .data_in         (data_in),
    .data_out        (data_out),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_count       (err_count),
    .first_err_valid (first_err_valid),
    .first_err_addr  (first_err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory with 1-cycle registered read; stuck bits forced to 1 on readback.
  always @(posedge clk) begin
    if (write) mem[addr] <= data_in;
    if (read)  data_out  <= mem[addr] | stuck[addr];
  end

  function automatic logic [7:0] model_lfsr(input logic [7:0] d);
    return {d[6:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
  endfunction

  function automatic logic [7:0] model_pat(input logic [1:0] m, input logic [4:0] a,
                                           input logic [7:0] r);
    case (m)
      2'b00:   return 8'h00;
      2'b01:   return {3'b000, a};
      2'b10:   return r;
      default: return a[0] ? 8'hAA : 8'h55;
    endcase
  endfunction

  // Push expected writes and predict the error summary for the current faults.
  task automatic prepare(input logic [1:0] m);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'hA5;
    exp_q.delete();
    exp_errs  = 0;
    exp_fv    = 1'b0;
    exp_faddr = 5'd0;
    for (int a = 0; a < 32; a++) begin
      wr_t w;
      logic [4:0] ai;
      ai  = a[4:0];
      p   = model_pat(m, ai, r);
      w.a = ai;
      w.d = p;
      exp_q.push_back(w);
      if ((p | stuck[a]) != p) begin
        exp_errs++;
        if (!exp_fv) begin
          exp_fv    = 1'b1;
          exp_faddr = ai;
        end
      end
      r = model_lfsr(r);
    end
  endtask

  // Start a test and observe 100 cycles; write transactions are scoreboarded.
  task automatic run_bist(input logic [1:0] m, input int stray_cycle,
                          output int done_cyc, output int done_cnt,
                          output int wr_cnt, output int rd_cnt,
                          output logic busy1, output logic busy98);
    wr_t w;
    done_cyc = -1;
    done_cnt = 0;
    wr_cnt   = 0;
    rd_cnt   = 0;
    busy1    = 1'b0;
    busy98   = 1'b1;
    prepare(m);
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (n == stray_cycle) begin
        start = 1'b1;
        mode  = ~m;
      end else begin
        start = 1'b0;
        mode  = m;
      end
      total++;
      if (read && write) begin
        bad++;
        $display("FAIL strobe_excl cycle=%0d read=%b write=%b required not both", n, read, write);
      end
      if (write) begin
        obs_wdata[addr] = data_in;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL wr_extra cycle=%0d addr=%0d required no write", n, addr);
        end else begin
          w = exp_q.pop_front();
          total++;
          if (addr !== w.a || data_in !== w.d) begin
            bad++;
            $display("FAIL wr_txn cycle=%0d got addr=%0d data=%h required addr=%0d data=%h",
                     n, addr, data_in, w.a, w.d);
          end
        end
        wr_cnt++;
      end
      if (read) begin
        total++;
        if (addr !== rd_cnt[4:0]) begin
          bad++;
          $display("FAIL rd_addr cycle=%0d got %0d required %0d", n, addr, rd_cnt[4:0]);
        end
        rd_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = n;
      end
      if (n == 1)  busy1  = busy;
      if (n == 98) busy98 = busy;
    end
    start = 1'b0;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL wr_missing got %0d outstanding required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    total++;
    if ({read, write, busy, done, pass, first_err_valid} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags got %b required 000000",
               {read, write, busy, done, pass, first_err_valid});
    end
    total++;
    if ({addr, data_in, err_count, first_err_addr} !== 24'h0) begin
      bad++;
      $display("FAIL reset_values got addr=%0d data_in=%h err=%0d faddr=%0d required 0",
               addr, data_in, err_count, first_err_addr);
    end
  endtask

  // Shared result checks after a run; each scenario calls it with its own name.
  task automatic test_summary(input string nm, input int done_cyc, input int done_cnt,
                              input int wr_cnt, input int rd_cnt,
                              input logic busy1, input logic busy98);
    total++;
    if (done_cyc !== 97 || done_cnt !== 1) begin
      bad++;
      $display("FAIL %s_done got cycle=%0d pulses=%0d required cycle=97 pulses=1",
               nm, done_cyc, done_cnt);
    end
    total++;
    if (wr_cnt !== 32 || rd_cnt !== 32) begin
      bad++;
      $display("FAIL %s_counts got wr=%0d rd=%0d required 32/32", nm, wr_cnt, rd_cnt);
    end
    total++;
    if (busy1 !== 1'b1 || busy98 !== 1'b0) begin
      bad++;
      $display("FAIL %s_busy got c1=%b c98=%b required 1/0", nm, busy1, busy98);
    end
    total++;
    if (err_count !== 6'(exp_errs)) begin
      bad++;
      $display("FAIL %s_err_count got %0d required %0d", nm, err_count, exp_errs);
    end
    total++;
    if (first_err_valid !== exp_fv || (exp_fv && first_err_addr !== exp_faddr)) begin
      bad++;
      $display("FAIL %s_first_err got v=%b a=%0d required v=%b a=%0d",
               nm, first_err_valid, first_err_addr, exp_fv, exp_faddr);
    end
    total++;
    if (pass !== (exp_errs == 0)) begin
      bad++;
      $display("FAIL %s_pass got %b required %b", nm, pass, (exp_errs == 0));
    end
  endtask

  task automatic clear_faults();
    for (int a = 0; a < 32; a++) stuck[a] = 8'h00;
  endtask

  task automatic test_addr_mode();
    int dc, dn, wc, rc;
    logic b1, b98;
    clear_faults();
    run_bist(2'b01, 0, dc, dn, wc, rc, b1, b98);
    test_summary("addr", dc, dn, wc, rc, b1, b98);
  endtask

  task automatic test_rand_mode();
    int dc, dn, wc, rc;
    logic b1, b98;
    clear_faults();
    run_bist(2'b10, 0, dc, dn, wc, rc, b1, b98);
    test_summary("rand", dc, dn, wc, rc, b1, b98);
    total++;
    if (obs_wdata[0] !== 8'hA5 || obs_wdata[1] !== 8'h4A) begin
      bad++;
      $display("FAIL rand_seed got %h %h required a5 4a", obs_wdata[0], obs_wdata[1]);
    end
  endtask

  // Bits 3 and 2 stuck at addr 7; AA already has bit 3 set so bit 2 exposes it.
  task automatic test_check_fault();
    int dc, dn, wc, rc;
    logic b1, b98;
    clear_faults();
    stuck[7] = 8'h0C;
    run_bist(2'b11, 0, dc, dn, wc, rc, b1, b98);
    test_summary("check", dc, dn, wc, rc, b1, b98);
    total++;
    if (err_count !== 6'd1 || first_err_addr !== 5'd7) begin
      bad++;
      $display("FAIL check_fixed got err=%0d faddr=%0d required 1/7", err_count, first_err_addr);
    end
  endtask

  task automatic test_zero_all_fail();
    int dc, dn, wc, rc;
    logic b1, b98;
    clear_faults();
    for (int a = 0; a < 32; a++) stuck[a] = 8'h01;
    run_bist(2'b00, 0, dc, dn, wc, rc, b1, b98);
    test_summary("zero", dc, dn, wc, rc, b1, b98);
    total++;
    if (err_count !== 6'd32) begin
      bad++;
      $display("FAIL zero_nowrap got %0d required 32", err_count);
    end
    clear_faults();
  endtask

  task automatic test_reset_mid();
    bit found;
    int dc, dn, wc, rc;
    logic b1, b98;
    found = 1'b0;
    @(negedge clk);
    mode  = 2'b01;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (write && addr == 5'd10) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL rst_wait got no write at addr 10 within 40 cycles required one");
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({write, read, busy, done} !== 4'b0) begin
      bad++;
      $display("FAIL rst_async got w=%b r=%b busy=%b done=%b required 0000",
               write, read, busy, done);
    end
    total++;
    if ({pass, first_err_valid} !== 2'b0 || err_count !== 6'd0 || first_err_addr !== 5'd0) begin
      bad++;
      $display("FAIL rst_results got pass=%b fv=%b err=%0d fa=%0d required 0",
               pass, first_err_valid, err_count, first_err_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_faults();
    run_bist(2'b01, 0, dc, dn, wc, rc, b1, b98);
    test_summary("after_rst", dc, dn, wc, rc, b1, b98);
  endtask

  task automatic test_start_ignored();
    int dc, dn, wc, rc;
    logic b1, b98;
    clear_faults();
    run_bist(2'b01, 40, dc, dn, wc, rc, b1, b98);
    test_summary("stray_start", dc, dn, wc, rc, b1, b98);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 2'b00;
    clear_faults();
    for (int a = 0; a < 32; a++) mem[a] = 8'h00;
    #1;
    test_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_addr_mode();
    test_rand_mode();
    test_check_fault();
    test_zero_all_fail();
    test_reset_mid();
    test_start_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
